// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: function codes and FSM states.
package alu_sched_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sched_alu4.sv
// 4-bit combinational ALU shared by both requesters.
module alu4
    import alu_sched_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] func,
    output logic [3:0] out,
    output logic       cout,
    output logic       overflow
);

    logic       is_sub;
    logic [3:0] b_op;
    logic [4:0] sum;
    logic       ovf;

    // Less-than reuses the subtractor: sign of (a - b) corrected by overflow.
    assign is_sub = (func == ALU_SUB) || (func == ALU_LT);
    assign b_op   = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_op} + {4'b0000, is_sub};
    assign ovf    = (a[3] == b_op[3]) && (sum[3] != a[3]);

    always_comb begin
        out      = 4'b0000;
        cout     = 1'b0;
        overflow = 1'b0;
        case (func)
            ALU_ADD, ALU_SUB: begin
                out      = sum[3:0];
                cout     = sum[4];
                overflow = ovf;
            end
            ALU_NOT: out = ~a;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_XOR: out = a ^ b;
            ALU_LT:  out = {4{sum[3] ^ ovf}};
            ALU_EQ:  out = {4{a == b}};
            default: out = 4'b0000;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin arbiter between two requesters feeding one registered ALU, with a
// held response slot and a completed-operation counter.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_func,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_func,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_out,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t     state;
    logic       rr_last;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [2:0] op_func;
    logic       op_id;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       alu_ovf;
    logic       grant0;
    logic       grant1;

    // On a tie the requester that did not win last time gets the slot.
    assign grant0 = rst_n && (state == ST_IDLE) && req0_valid && (!req1_valid || rr_last);
    assign grant1 = rst_n && (state == ST_IDLE) && req1_valid && (!req0_valid || !rr_last);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    alu4 u_alu (
        .a        (op_a),
        .b        (op_b),
        .func     (op_func),
        .out      (alu_out),
        .cout     (alu_cout),
        .overflow (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_last      <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            op_func      <= '0;
            op_id        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_out      <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        op_a    <= grant1 ? req1_a    : req0_a;
                        op_b    <= grant1 ? req1_b    : req0_b;
                        op_func <= grant1 ? req1_func : req0_func;
                        op_id   <= grant1;
                        rr_last <= grant1;
                        busy    <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out      <= alu_out;
                    rsp_cout     <= alu_cout;
                    rsp_overflow <= alu_ovf;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, stall/reset/fairness
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_func = 0, req1_func = 0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_overflow, busy;
    logic [3:0] rsp_out;
    logic [7:0] op_count;
    logic       r0_2, r1_2, rv_2, rid_2, rc_2, ro_2, busy_2;
    logic [3:0] rout_2;
    logic [1:0] op_count2;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .busy(busy), .op_count(op_count)
    );

    // Narrow-counter copy driven by the same stimulus, used only for wrap checks.
    alu_sched #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(r0_2), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(r1_2), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp_valid(rv_2), .rsp_ready(rsp_ready), .rsp_id(rid_2), .rsp_out(rout_2),
        .rsp_cout(rc_2), .rsp_overflow(ro_2), .busy(busy_2), .op_count(op_count2)
    );

    typedef struct {
        int id, a, b, f;
        int out, cout, ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 7) ? v - 16 : v;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic alu_ref(input int a, b, f, output int out, cout, ovf);
        int r, s;
        out = 0; cout = 0; ovf = 0;
        case (f)
            0: begin r = a + b; s = sgn(a) + sgn(b); out = r % 16; cout = (r > 15); ovf = (s > 7 || s < -8); end
            1: begin r = a + (15 - b) + 1; s = sgn(a) - sgn(b); out = r % 16; cout = (r > 15); ovf = (s > 7 || s < -8); end
            2: out = 15 - a;
            3: out = a & b;
            4: out = a | b;
            5: out = a ^ b;
            6: out = (sgn(a) < sgn(b)) ? 15 : 0;
            default: out = (a == b) ? 15 : 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 0;
        tick();
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_op_count", op_count, 0);
        check("reset_rsp_out", {rsp_id, rsp_cout, rsp_overflow, rsp_out}, 0);
        rst_n = 1; req0_valid = 0; req1_valid = 0;
        exp_cnt = 0;
    endtask

    task automatic run_op(input int id, a, b, f, e_out, e_cout, e_ovf, stall);
        int waited;
        if (id == 0) begin req0_a = a[3:0]; req0_b = b[3:0]; req0_func = f[2:0]; req0_valid = 1; end
        else         begin req1_a = a[3:0]; req1_b = b[3:0]; req1_func = f[2:0]; req1_valid = 1; end
        rsp_ready = 1;  // must be ignored outside RESP
        #1;
        waited = 0;
        while (!((id == 0) ? req0_ready : req1_ready) && waited < 20) begin
            tick(); #1; waited++;
        end
        if (waited >= 20) begin
            check("grant_timeout", 0, 1);
            req0_valid = 0; req1_valid = 0; rsp_ready = 0;
            return;
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        rsp_ready = (stall == 0);
        tick();
        check("rsp_valid_t2", rsp_valid, 1);
        check("rsp_out", rsp_out, e_out);
        check("rsp_cout", rsp_cout, e_cout);
        check("rsp_overflow", rsp_overflow, e_ovf);
        check("rsp_id", rsp_id, id);
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1; req1_valid = 1;
            tick();
            check("stall_valid", rsp_valid, 1);
            check("stall_out", rsp_out, e_out);
            check("stall_busy", busy, 1);
            check("stall_ready", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        exp_cnt++;
        check("done_busy", busy, 0);
        check("done_rsp_valid", rsp_valid, 0);
        check("op_count", op_count, exp_cnt % 256);
        check("op_count_w2", op_count2, exp_cnt % 4);
    endtask

    initial begin
        vec_t vt[13];
        int o, c, v, g_exp, last_cyc, cyc, waited;
        int gq[$];

        vt[0]  = '{0, 7, 1, 0, 8, 0, 1};
        vt[1]  = '{1, 5, 3, 1, 2, 1, 0};
        vt[2]  = '{1, 3, 5, 6, 15, 0, 0};
        vt[3]  = '{0, 9, 9, 7, 15, 0, 0};
        vt[4]  = '{0, 15, 1, 0, 0, 1, 0};
        vt[5]  = '{1, 8, 1, 1, 7, 1, 1};
        vt[6]  = '{0, 12, 10, 2, 3, 0, 0};
        vt[7]  = '{0, 12, 10, 3, 8, 0, 0};
        vt[8]  = '{1, 12, 10, 4, 14, 0, 0};
        vt[9]  = '{0, 12, 10, 5, 6, 0, 0};
        vt[10] = '{1, 5, 3, 6, 0, 0, 0};
        vt[11] = '{0, 9, 4, 6, 15, 0, 0};
        vt[12] = '{1, 9, 8, 7, 0, 0, 0};

        do_reset();
        foreach (vt[i])
            run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].f, vt[i].out, vt[i].cout, vt[i].ovf, 0);

        // Consumer back-pressure for five cycles.
        run_op(0, 6, 5, 0, 11, 0, 1, 5);

        for (int n = 0; n < 30; n++) begin
            int a, b, f, id;
            id = $urandom_range(0, 1); a = $urandom_range(0, 15);
            b = $urandom_range(0, 15); f = $urandom_range(0, 7);
            alu_ref(a, b, f, o, c, v);
            run_op(id, a, b, f, o, c, v, $urandom_range(0, 2));
        end

        // Reset while the operation is in EXEC: it must vanish.
        req1_a = 3; req1_b = 5; req1_func = 0; req1_valid = 1; rsp_ready = 0;
        #1;
        waited = 0;
        while (!req1_ready && waited < 20) begin tick(); #1; waited++; end
        check("rst_exec_grant", req1_ready, 1);
        tick();
        req1_valid = 0; rst_n = 0;
        tick();
        rst_n = 1; exp_cnt = 0;
        check("rst_exec_rsp_valid", rsp_valid, 0);
        check("rst_exec_busy", busy, 0);
        check("rst_exec_count", op_count, 0);
        tick();
        check("rst_exec_rsp_valid2", rsp_valid, 0);

        // Both requesters continuously valid: alternate grants, one every 3 cycles.
        req0_a = 2; req0_b = 3; req0_func = 0; req1_a = 4; req1_b = 4; req1_func = 7;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        #1;
        g_exp = 0; last_cyc = -1;
        for (cyc = 0; cyc < 24; cyc++) begin
            if (req0_ready || req1_ready) begin
                check("rr_grant", {req1_ready, req0_ready}, (g_exp == 0) ? 1 : 2);
                if (last_cyc >= 0) check("rr_spacing", cyc - last_cyc, 3);
                gq.push_back(g_exp);
                last_cyc = cyc; g_exp = 1 - g_exp;
            end
            if (rsp_valid) begin
                if (gq.size() == 0) check("rr_unexpected_rsp", 1, 0);
                else begin
                    int gid;
                    gid = gq.pop_front();
                    check("rr_rsp_id", rsp_id, gid);
                    check("rr_rsp_out", rsp_out, (gid == 0) ? 5 : 15);
                    exp_cnt++;
                end
            end
            tick(); #1;
        end
        req0_valid = 0; req1_valid = 0;
        waited = 0;
        while (busy && waited < 10) begin
            if (rsp_valid) begin void'(gq.pop_front()); exp_cnt++; end
            tick(); waited++;
        end
        check("rr_drain", busy, 0);
        check("rr_op_count", op_count, exp_cnt % 256);
        check("rr_accepts", exp_cnt >= 7, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
